// File: rtl/exe_pkg.sv
// Shared encodings for the EXE-stage multiply/divide controller.
// The md_op values match the decoder's field. Op 7 is treated as NONE.
package exe_pkg;
   localparam int WORD = 32;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MULT = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   function automatic logic [WORD-1:0] cond_neg(input logic neg, input logic [WORD-1:0] v);
      return neg ? -v : v;
   endfunction
endpackage

// File: rtl/exe_md_ctrl_if.sv
// ID->EXE register outputs and EXE->MEM handshake for the mul/div controller.
// The master side is the pipeline fabric. The slave side is exe_md_ctrl.
interface exe_md_ctrl_if;
   import exe_pkg::*;

   logic [2:0]      exe_md_op;
   logic [WORD-1:0] exe_src_a;
   logic [WORD-1:0] exe_src_b;
   logic            MEM_allow_in;
   logic            EXE_over;
   logic            EXE_allow_in;
   logic [WORD-1:0] hi_out;
   logic [WORD-1:0] lo_out;
   logic            md_busy;

   modport master (
      output exe_md_op, exe_src_a, exe_src_b, MEM_allow_in,
      input  EXE_over, EXE_allow_in, hi_out, lo_out, md_busy
   );
   modport slave (
      input  exe_md_op, exe_src_a, exe_src_b, MEM_allow_in,
      output EXE_over, EXE_allow_in, hi_out, lo_out, md_busy
   );
endinterface

// File: rtl/div_iter.sv
// Unsigned radix-2 restoring divider. It retires one quotient bit per enabled step.
// Dividing by zero naturally gives an all-ones quotient and remainder = dividend.
module div_iter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         step,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);
   logic [W-1:0] rem_q, quo_q, dsr_q;
   logic [W:0]   shifted, trial;

   // Bit W of trial is set exactly when the shifted remainder is below the divisor.
   always_comb begin
      shifted = {rem_q, quo_q[W-1]};
      trial   = shifted - {1'b0, dsr_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
      end else if (start) begin
         rem_q <= '0;
         quo_q <= dividend;
         dsr_q <= divisor;
      end else if (step) begin
         rem_q <= trial[W] ? shifted[W-1:0] : trial[W-1:0];
         quo_q <= {quo_q[W-2:0], ~trial[W]};
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
endmodule

// File: rtl/exe_md_ctrl.sv
// EXE-stage multiply/divide sequencer with EXE_over/EXE_allow_in handshake.
// It owns the architectural HI/LO, which update only on a clean handoff to MEM.
module exe_md_ctrl
   import exe_pkg::*;
#(
   parameter int DIV_STEPS = 32,
   parameter int MUL_LAT   = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cancel,
   exe_md_ctrl_if.slave md
);
   localparam int CW = $clog2(DIV_STEPS + 1);

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [WORD-1:0]   a_mag_q, b_mag_q, hi_res, lo_res, hi_q, lo_q;
   logic              neg_q, neg_r, is_div_q;

   logic              op_mul, op_div, op_start, op_signed, sa, sb;
   logic              exe_over, handoff;
   logic [WORD-1:0]   a_mag, b_mag, div_q, div_r, done_hi, done_lo;
   logic [2*WORD-1:0] prod, prod_fix;

   always_comb begin
      op_mul    = (md.exe_md_op == MD_MULT) || (md.exe_md_op == MD_MULTU);
      op_div    = (md.exe_md_op == MD_DIV)  || (md.exe_md_op == MD_DIVU);
      op_start  = op_mul || op_div;
      op_signed = (md.exe_md_op == MD_MULT) || (md.exe_md_op == MD_DIV);
      sa        = op_signed && md.exe_src_a[WORD-1];
      sb        = op_signed && md.exe_src_b[WORD-1];
      a_mag     = cond_neg(sa, md.exe_src_a);
      b_mag     = cond_neg(sb, md.exe_src_b);
      exe_over  = ((state == ST_IDLE) && !op_start) || (state == ST_DONE);
      handoff   = exe_over && md.MEM_allow_in;
   end

   // The operands are held stable for the whole MULT phase. The multiplier therefore
   // has MUL_LAT cycles to settle before the product is registered.
   always_comb begin
      prod     = 64'(a_mag_q) * 64'(b_mag_q);
      prod_fix = neg_q ? -prod : prod;
      done_hi  = is_div_q ? cond_neg(neg_r, div_r) : hi_res;
      done_lo  = is_div_q ? cond_neg(neg_q, div_q) : lo_res;
   end

   div_iter #(.W(WORD)) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     ((state == ST_IDLE) && op_div && !cancel),
      .step      ((state == ST_DIV) && !cancel),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (div_q),
      .remainder (div_r)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         a_mag_q  <= '0;
         b_mag_q  <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         is_div_q <= 1'b0;
         hi_res   <= '0;
         lo_res   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else if (cancel) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (op_start) begin
                  state    <= op_mul ? ST_MULT : ST_DIV;
                  cnt      <= op_mul ? CW'(MUL_LAT) : CW'(DIV_STEPS);
                  a_mag_q  <= a_mag;
                  b_mag_q  <= b_mag;
                  neg_q    <= sa ^ sb;
                  neg_r    <= sa;
                  is_div_q <= op_div;
               end else if (handoff) begin
                  if (md.exe_md_op == MD_MTHI) hi_q <= md.exe_src_a;
                  if (md.exe_md_op == MD_MTLO) lo_q <= md.exe_src_a;
               end
            end
            ST_MULT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state  <= ST_DONE;
                  hi_res <= prod_fix[2*WORD-1:WORD];
                  lo_res <= prod_fix[WORD-1:0];
               end
            end
            ST_DIV: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= ST_DONE;
            end
            default: begin
               // The upstream register reloads on this same edge, so IDLE never sees the stale op.
               if (handoff) begin
                  state <= ST_IDLE;
                  hi_q  <= done_hi;
                  lo_q  <= done_lo;
               end
            end
         endcase
      end
   end

   assign md.EXE_over     = exe_over;
   assign md.EXE_allow_in = handoff;
   assign md.hi_out       = hi_q;
   assign md.lo_out       = lo_q;
   assign md.md_busy      = (state == ST_MULT) || (state == ST_DIV);
endmodule
